uart_rx_os: RTL and testbench

Parametrised oversampling UART receiver, next generation of the team's fixed 8N1 receive FSM. It samples the serial line mid-bit using an internal oversample tick and supports 5–9 data bits, 1 or 2 stop bits and optional parity. It reports framing, parity and overrun errors and delivers each word over a valid/ready handshake. It sits between the pad-side `rx` line and the byte consumer (FIFO or register file).

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_os_tick.sv | 23 ++
 rtl/uart_rx_os.sv | 202 ++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the oversampling UART receiver and its companion blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_t;

  // Oversample tick divider, floored and never below 1.
  function automatic int uart_div(input int clk_hz, input int baud, input int os);
    int d;
    d = clk_hz / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic int uart_cnt_w(input int data_bits);
    return $clog2(data_bits + 1);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Free-running oversample tick generator: one-cycle pulse every DIV clocks.
module uart_os_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)            cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver, 5..9 data bits, 1..2 stop bits, valid/ready output.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV = uart_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int CW  = uart_cnt_w(DATA_BITS);
  localparam int PW  = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] PH_MID    = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PH_END    = PW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

  logic                 rx_p0, rx_p1, tick;
  uart_rx_state_t       state, state_n;
  logic [PW-1:0]        ph, ph_n, ph_step;
  logic [CW-1:0]        bcnt, bcnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 ferr_acc, ferr_acc_n, cm_ferr, commit;
`ifdef UART_RX_PARITY_EN
  logic                 perr_acc, perr_acc_n, perr_q;
`else
  logic                 unused_par_odd;
  assign unused_par_odd = PARITY_ODD[0];
`endif

  uart_os_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign ph_step = (ph == PH_END) ? '0 : ph + PW'(1);
  assign cm_ferr = ferr_acc | ~rx_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_p0    <= 1'b1;
      rx_p1    <= 1'b1;
      state    <= IDLE;
      ph       <= '0;
      bcnt     <= '0;
      shreg    <= '0;
      ferr_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_acc <= 1'b0;
`endif
    end else begin
      rx_p0    <= rx;
      rx_p1    <= rx_p0;
      state    <= state_n;
      ph       <= ph_n;
      bcnt     <= bcnt_n;
      shreg    <= shreg_n;
      ferr_acc <= ferr_acc_n;
`ifdef UART_RX_PARITY_EN
      perr_acc <= perr_acc_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    ph_n       = ph;
    bcnt_n     = bcnt;
    shreg_n    = shreg;
    ferr_acc_n = ferr_acc;
    commit     = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_acc_n = perr_acc;
`endif
    case (state)
      IDLE: begin
        if (!rx_p1) begin
          ph_n       = '0;
          bcnt_n     = '0;
          ferr_acc_n = 1'b0;
`ifdef UART_RX_PARITY_EN
          perr_acc_n = 1'b0;
`endif
          state_n    = START;
        end
      end
      START: begin
        // Mid-start-bit check rejects short glitches on the idle line.
        if (tick) begin
          if (ph == PH_MID) begin
            ph_n    = '0;
            state_n = rx_p1 ? IDLE : DATA;
          end else begin
            ph_n = ph + PW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          ph_n = ph_step;
          if (ph == PH_END) begin
            shreg_n = {rx_p1, shreg[DATA_BITS-1:1]};
            if (bcnt == LAST_DATA) begin
              bcnt_n  = '0;
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              bcnt_n = bcnt + CW'(1);
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          ph_n = ph_step;
          if (ph == PH_END) begin
            perr_acc_n = ((^shreg) ^ rx_p1) != PARITY_ODD[0];
            state_n    = STOP;
          end
        end
      end
`endif
      STOP: begin
        // bcnt is reused as the stop-bit index; a low final stop bit means a break.
        if (tick) begin
          ph_n = ph_step;
          if (ph == PH_END) begin
            ferr_acc_n = cm_ferr;
            if (bcnt == LAST_STOP) begin
              commit  = 1'b1;
              state_n = rx_p1 ? IDLE : BREAK;
            end else begin
              bcnt_n = bcnt + CW'(1);
            end
          end
        end
      end
      BREAK: begin
        if (rx_p1) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else if (commit && (!rx_valid || rx_ready)) begin
      rx_data   <= shreg;
      rx_valid  <= 1'b1;
      frame_err <= cm_ferr;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_acc;
`endif
    end else if (commit) begin
      overrun   <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Randomized bench for uart_rx_os: an 8N1 instance and a 9-data/2-stop instance against a word-level model.
module tb_uart_rx_os;

  localparam int CLK_HZ  = 1_600_000;
  localparam int BAUD    = 100_000;
  localparam int OS      = 16;
  localparam int PODD    = 0;
  localparam int BIT_CLK = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8_n = 1'b0, rx8 = 1'b1, rdy8 = 1'b0;
  logic [7:0] d8;
  logic       v8, fe8, pe8, ov8, bz8;
  logic       rst9_n = 1'b0, rx9 = 1'b1, rdy9 = 1'b0;
  logic [8:0] d9;
  logic       v9, fe9, pe9, ov9, bz9;

  uart_rx_os #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
               .STOP_BITS(1), .PARITY_ODD(PODD)) dut8 (
    .clk(clk), .rst_n(rst8_n), .rx(rx8), .rx_data(d8), .rx_valid(v8), .rx_ready(rdy8),
    .frame_err(fe8), .parity_err(pe8), .overrun(ov8), .busy(bz8));

  uart_rx_os #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(9),
               .STOP_BITS(2), .PARITY_ODD(PODD)) dut9 (
    .clk(clk), .rst_n(rst9_n), .rx(rx9), .rx_data(d9), .rx_valid(v9), .rx_ready(rdy9),
    .frame_err(fe9), .parity_err(pe9), .overrun(ov9), .busy(bz9));

  int tests = 0;
  int fails = 0;
  logic [10:0] q8[$];
  logic [10:0] q9[$];
  int vcnt8 = 0, bcnt8 = 0, vcnt9 = 0;

  // Observed words, packed as {parity_err, frame_err, data[8:0]}, taken on each handshake.
  always @(negedge clk) begin
    if (rst8_n && v8) vcnt8++;
    if (rst8_n && bz8) bcnt8++;
    if (rst9_n && v9) vcnt9++;
    if (rst8_n && v8 && rdy8) q8.push_back({pe8, fe8, 1'b0, d8});
    if (rst9_n && v9 && rdy9) q9.push_back({pe9, fe9, d9});
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Parity bit that makes the frame clean: (ones(data) + p) mod 2 == PODD.
  function automatic bit good_par(input logic [8:0] d, input int n);
    int ones = 0;
    for (int i = 0; i < n; i++) ones += int'(d[i]);
    return bit'((ones + PODD) % 2);
  endfunction

  function automatic logic [10:0] model_word(input logic [8:0] d, input int n, input bit p,
                                             input logic [1:0] stopv, input int nstop);
    int ones = 0;
    bit fe = 1'b0;
    bit pe;
    for (int i = 0; i < n; i++) ones += int'(d[i]);
    for (int s = 0; s < nstop; s++) if (!stopv[s]) fe = 1'b1;
    pe = PAR_EN && (((ones + int'(p)) % 2) != PODD);
    return {pe, fe, (n == 8) ? {1'b0, d[7:0]} : d};
  endfunction

  task automatic drive_bit(input int which, input bit v);
    if (which == 0) rx8 = v; else rx9 = v;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int which, input int n);
    if (which == 0) rx8 = 1'b1; else rx9 = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int which, input logic [8:0] d, input int n, input bit p,
                            input logic [1:0] stopv, input int nstop);
    drive_bit(which, 1'b0);
    for (int i = 0; i < n; i++) drive_bit(which, d[i]);
    if (PAR_EN) drive_bit(which, p);
    for (int s = 0; s < nstop; s++) drive_bit(which, stopv[s]);
  endtask

  task automatic expect_word(input int which, input string tag, input logic [10:0] exp);
    int n = 0;
    logic [10:0] got;
    while (n < 48 && ((which == 0) ? (q8.size() == 0) : (q9.size() == 0))) begin
      @(posedge clk); #1; n++;
    end
    if (which == 0 && q8.size() > 0)      got = q8.pop_front();
    else if (which == 1 && q9.size() > 0) got = q9.pop_front();
    else                                  got = 11'h7FF;
    check_val(tag, 32'(got), 32'(exp));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] d;
    logic [1:0] sv;
    bit         p;
    int         base, bbase;

    repeat (4) @(posedge clk);
    #1;
    check_val("rst8_outs", {d8, v8, fe8, pe8, ov8, bz8}, 0);
    check_val("rst9_outs", {d9, v9, fe9, pe9, ov9, bz9}, 0);
    rst8_n = 1'b1; rst9_n = 1'b1;
    rdy8 = 1'b1; rdy9 = 1'b1;
    idle(0, 10);

    // 1: single word, permanent ready -> one-cycle valid pulse
    base = vcnt8;
    send_frame(0, 9'h0A5, 8, good_par(9'h0A5, 8), 2'b11, 1);
    expect_word(0, "t1_a5", model_word(9'h0A5, 8, good_par(9'h0A5, 8), 2'b11, 1));
    idle(0, 6);
    check_val("t1_pulse", vcnt8 - base, 1);
    check_val("t1_busy", bz8, 0);

    // 2: overrun with consumer stalled
    rdy8 = 1'b0;
    send_frame(0, 9'h03C, 8, good_par(9'h03C, 8), 2'b11, 1);
    idle(0, 4);
    send_frame(0, 9'h05A, 8, good_par(9'h05A, 8), 2'b11, 1);
    idle(0, 4);
    check_val("t2_data", d8, 8'h3C);
    check_val("t2_valid_ovr", {v8, ov8, fe8}, 3'b110);
    rdy8 = 1'b1;
    @(posedge clk); @(negedge clk);
    check_val("t2_cleared", {v8, ov8, fe8, pe8}, 0);
    expect_word(0, "t2_word", model_word(9'h03C, 8, good_par(9'h03C, 8), 2'b11, 1));

    // 3: short glitch on an idle line
    idle(0, 10);
    base = vcnt8; bbase = bcnt8;
    rx8 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    idle(0, 40);
    check_val("t3_busy_short", ((bcnt8 - bbase) > 0 && (bcnt8 - bbase) < 12), 1);
    check_val("t3_no_valid", vcnt8 - base, 0);

    // 4: framing error followed by a held break, then a clean word
    send_frame(0, 9'h081, 8, good_par(9'h081, 8), 2'b00, 1);
    rx8 = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    expect_word(0, "t4_ferr", model_word(9'h081, 8, good_par(9'h081, 8), 2'b00, 1));
    check_val("t4_break_busy", bz8, 1);
    check_val("t4_no_extra", q8.size(), 0);
    idle(0, 8);
    check_val("t4_break_exit", bz8, 0);
    send_frame(0, 9'h055, 8, good_par(9'h055, 8), 2'b11, 1);
    expect_word(0, "t4_55", model_word(9'h055, 8, good_par(9'h055, 8), 2'b11, 1));
    idle(0, 5);

`ifdef UART_RX_PARITY_EN
    // 5: parity mismatch, then correct parity
    send_frame(0, 9'h007, 8, 1'b0, 2'b11, 1);
    expect_word(0, "t5_bad_par", {1'b1, 1'b0, 9'h007});
    idle(0, 5);
    send_frame(0, 9'h007, 8, 1'b1, 2'b11, 1);
    expect_word(0, "t5_good_par", {1'b0, 1'b0, 9'h007});
    idle(0, 5);
`endif

    // randomized words on the 8N1 instance
    for (int i = 0; i < 20; i++) begin
      d  = 9'($urandom_range(0, 255));
      p  = good_par(d, 8) ^ ($urandom_range(0, 4) == 0);
      sv = ($urandom_range(0, 5) == 0) ? 2'b00 : 2'b11;
      send_frame(0, d, 8, p, sv, 1);
      expect_word(0, $sformatf("rnd8_%0d", i), model_word(d, 8, p, sv, 1));
      idle(0, $urandom_range(2, 12));
    end

    // 6: 9 data bits, 2 stop bits, then reset mid-frame
    idle(1, 10);
    send_frame(1, 9'h1FF, 9, good_par(9'h1FF, 9), 2'b11, 2);
    expect_word(1, "t6_1ff", model_word(9'h1FF, 9, good_par(9'h1FF, 9), 2'b11, 2));
    idle(1, 6);
    for (int i = 0; i < 5; i++) begin
      d  = 9'($urandom_range(0, 511));
      p  = good_par(d, 9) ^ ($urandom_range(0, 4) == 0);
      sv = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) sv = 2'b11;
      send_frame(1, d, 9, p, sv, 2);
      expect_word(1, $sformatf("rnd9_%0d", i), model_word(d, 9, p, sv, 2));
      idle(1, $urandom_range(3, 12));
    end
    drive_bit(1, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1, i[0]);
    rst9_n = 1'b0;
    rx9 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("t6_rst_outs", {d9, v9, fe9, pe9, ov9, bz9}, 0);
    rst9_n = 1'b1;
    base = vcnt9;
    repeat (300) @(posedge clk);
    #1;
    check_val("t6_no_commit", vcnt9 - base, 0);
    check_val("t6_q_empty", q9.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
